// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and HI/LO select constants for muldiv_unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULTU = 3'd0,
    OP_MULT  = 3'd1,
    OP_DIVU  = 3'd2,
    OP_DIV   = 3'd3,
    OP_MADDU = 3'd4,
    OP_MADD  = 3'd5,
    OP_MSUBU = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  localparam logic SEL_HI = 1'b0;
  localparam logic SEL_LO = 1'b1;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - command, direct-write and HI/LO result bundle of muldiv_unit
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_we;
  logic             hilo_sel;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hilo_we, hilo_sel, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hilo_we, hilo_sel, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_div_seq.sv
// rtl/muldiv_div_seq.sv - restoring radix-2 divider on operand magnitudes, one quotient bit per cycle
module muldiv_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    mag_a   = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b   = (is_signed && b[WIDTH-1]) ? -b : b;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    if (start) begin
      quo_d = mag_a;
      rem_d = '0;
      dvs_d = mag_b;
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      // Negative trial difference means restore: keep the shifted remainder.
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy      = (cnt_q != '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MUL/DIV unit with architectural HI/LO registers
// Optional MULDIV_MADD_EN enables the MADD/MSUB accumulate ops (op 4..7).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 17);
  localparam int W2    = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d;
  logic [W2-1:0]    res_q, res_d;
  logic             dz_q, dz_d, qneg_q, qneg_d, rneg_q, rneg_d;

  logic             is_signed, is_div, op_ok, accept, done;
  logic [W2-1:0]    ext_a, ext_b, product, mul_val;
  logic             div_busy;
  logic [WIDTH-1:0] div_quo, div_rem;

  always_comb begin
    is_signed = bus.op[0];
    is_div    = op_is_div(bus.op);
    ext_a     = is_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    ext_b     = is_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    product   = ext_a * ext_b;
  end

`ifdef MULDIV_MADD_EN
  logic [W2-1:0] acc;
  assign op_ok = 1'b1;
  // Accumulate base is the HI/LO value at accept, so the whole result is registered then.
  always_comb begin
    acc = {hi_q, lo_q};
    if (!op_is_acc(bus.op))     mul_val = product;
    else if (op_is_sub(bus.op)) mul_val = acc - product;
    else                        mul_val = acc + product;
  end
`else
  assign op_ok   = !op_is_acc(bus.op);
  assign mul_val = product;
`endif

  assign accept = (state_q == ST_IDLE) && bus.start && op_ok;

  muldiv_div_seq #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_div),
    .a         (bus.a),
    .b         (bus.b),
    .is_signed (is_signed),
    .busy      (div_busy),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    a_d     = a_q;
    dz_d    = dz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d    = bus.a;
          dz_d   = (bus.b == '0);
          qneg_d = is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          rneg_d = is_signed && bus.a[WIDTH-1];
          res_d  = mul_val;
          if (is_div) begin
            state_d = ST_DIV;
            cnt_d   = CNT_W'(WIDTH - 1);
          end else begin
            state_d = ST_MUL;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
          end
        end else if (bus.hilo_we) begin
          if (bus.hilo_sel == SEL_HI) hi_d = bus.wdata;
          else                        lo_d = bus.wdata;
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = res_q;
          done         = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_FIX: begin
        if (!div_busy) begin
          // Divide by zero bypasses sign fix-up: quotient all ones, remainder is the dividend.
          if (dz_q) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = qneg_q ? -div_quo : div_quo;
            hi_d = rneg_q ? -div_rem : div_rem;
          end
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      a_q     <= '0;
      dz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      a_q     <= a_d;
      dz_q    <= dz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with an arithmetic reference model
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          passes = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  function automatic bit op_enabled(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
    return 1'b1;
`else
    return !op[2];
`endif
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] acc);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    if (op == 3'd2) begin
      if (y == 0) return {x, 32'hFFFF_FFFF};
      return {x % y, x / y};
    end
    if (op == 3'd3) begin
      if (y == 0) return {x, 32'hFFFF_FFFF};
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, x};
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    if (op[0]) p = sx * sy;
    else       p = {32'd0, x} * {32'd0, y};
    if (!op[2]) return p;
    return op[1] ? acc - p : acc + p;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit busy_now);
    logic [63:0] r;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = x;
    bus.b     = y;
    if (!busy_now && op_enabled(op)) begin
      r = ref_result(op, x, y, {m_hi, m_lo});
      sb.push_back(r);
      {m_hi, m_lo} = r;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic hilo_write(input logic sel, input logic [31:0] data, input bit busy_now);
    @(posedge clk); #1;
    bus.hilo_we  = 1'b1;
    bus.hilo_sel = sel;
    bus.wdata    = data;
    if (!busy_now) begin
      if (sel == SEL_HI) m_hi = data;
      else               m_lo = data;
    end
    @(posedge clk); #1;
    bus.hilo_we = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int n, lat;
    issue(op, x, y, 1'b0);
    wait_idle(n);
    if (!op_enabled(op))          lat = 0;
    else if (op[2:1] == 2'b01)    lat = W + 1;
    else                          lat = MC;
    check($sformatf("busy_cycles_op%0d", op), 64'(n), 64'(lat));
  endtask

  initial begin : monitor
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL done_unexpected: done=1 with 0 results pending, required no done");
        end else begin
          passes++;
          exp = sb.pop_front();
          @(posedge clk); #1;
          check("sb_result", {bus.hi, bus.lo}, exp);
          check("done_single_pulse", 64'(bus.done), 64'd0);
        end
      end
    end
  end

  initial begin : timeout
    #500000;
    $display("FAIL timeout: simulation did not complete by %0t", $time);
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int          n;
    logic [2:0]  op;
    logic [31:0] x, y;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.op       = '0;
    bus.a        = '0;
    bus.b        = '0;
    bus.hilo_we  = 1'b0;
    bus.hilo_sel = 1'b0;
    bus.wdata    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    reset = 1'b0;

    run_op(3'd1, 32'hFFFF_FFFD, 32'd7);
    check("mult_m3_x7", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd2, 32'd7, 32'd0);
    check("divu_7_0", {bus.hi, bus.lo}, 64'h0000_0007_FFFF_FFFF);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_m1", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd0);
    check("div_m7_0", {bus.hi, bus.lo}, 64'hFFFF_FFF9_FFFF_FFFF);

    issue(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("busy_during_div", 64'(bus.busy), 64'd1);
    issue(3'd0, 32'd2, 32'd3, 1'b1);
    hilo_write(SEL_LO, 32'd55, 1'b1);
    wait_idle(n);
    check("busy_window_result", {bus.hi, bus.lo}, {32'd2, 32'd14});

    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.op       = 3'd0;
    bus.a        = 32'd3;
    bus.b        = 32'd3;
    bus.hilo_we  = 1'b1;
    bus.hilo_sel = SEL_LO;
    bus.wdata    = 32'd77;
    sb.push_back(64'd9);
    {m_hi, m_lo} = 64'd9;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.hilo_we = 1'b0;
    wait_idle(n);
    check("start_beats_hilo_we", {bus.hi, bus.lo}, 64'd9);

    hilo_write(SEL_HI, 32'd0, 1'b0);
    hilo_write(SEL_LO, 32'd10, 1'b0);
    check("preload", {bus.hi, bus.lo}, 64'd10);
    run_op(3'd4, 32'd4, 32'd5);
`ifdef MULDIV_MADD_EN
    check("maddu_4x5", {bus.hi, bus.lo}, 64'd30);
`else
    check("maddu_ignored", {bus.hi, bus.lo}, 64'd10);
`endif
    run_op(3'd7, 32'd1, 32'd31);
`ifdef MULDIV_MADD_EN
    check("msub_1x31", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check("msub_ignored", {bus.hi, bus.lo}, 64'd10);
`endif

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 50); y = $urandom_range(1, 9); end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) hilo_write(1'($urandom_range(0, 1)), $urandom, 1'b0);
      run_op(op, x, y);
    end
    check("model_tracks_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

    issue(3'd3, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    {m_hi, m_lo} = 64'd0;
    #1;
    check("reset_mid_busy", 64'(bus.busy), 64'd0);
    check("reset_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    run_op(3'd0, 32'd2, 32'd3);
    check("after_reset_multu", {bus.hi, bus.lo}, 64'd6);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width and HI/LO width.
REQ-002 Parameter MUL_CYCLES, default 5: multiply busy latency in cycles; legal range 1..16.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: launch the operation selected by op; sampled only when busy=0.
REQ-006 Port op, input, 3: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MADDU, 5 MADD, 6 MSUBU, 7 MSUB.
REQ-007 Ports a, b, input, WIDTH each: operands; a is the dividend, b is the divisor.
REQ-008 Port hilo_we, input, 1: direct write (mthi/mtlo).
REQ-009 Port hilo_sel, input, 1: 0 selects HI, 1 selects LO, for direct writes.
REQ-010 Port wdata, input, WIDTH: direct write data.
REQ-011 Port busy, output, 1: operation in flight.
REQ-012 Port done, output, 1: one-cycle pulse in the cycle HI/LO take a result.
REQ-013 Ports hi, lo, output, WIDTH each: architectural HI/LO registers.

Function
REQ-014 States SHALL be IDLE, MUL, DIV, FIX; leaving IDLE requires start=1 and busy=0.
REQ-015 Start accepted in IDLE: operands SHALL be latched; busy=1 from the next cycle.
REQ-016 MUL path: the full 2*WIDTH product (signed for odd op, unsigned for even op) SHALL be registered at accept.
  - Counter runs MUL_CYCLES cycles; on the last cycle {hi,lo} updates, done=1, then IDLE.
  - busy is high for exactly MUL_CYCLES cycles.
REQ-017 MADD/MSUB ({hi,lo} +/- product, modulo 2^(2*WIDTH)) SHALL use the {hi,lo} value held at accept, with MUL latency.
REQ-018 DIV path: restoring radix-2 divider on operand magnitudes, one quotient bit per cycle, WIDTH cycles in DIV, then one FIX cycle.
  - FIX applies signs for DIV: quotient negative if signs differ; remainder takes the dividend's sign.
  - On FIX: lo=quotient, hi=remainder, done=1, then IDLE.
  - busy is high for WIDTH+1 cycles.
REQ-019 Divide by zero SHALL still take WIDTH+1 cycles and produce lo=all ones, hi=a.
REQ-020 DIV with a=most-negative and b=-1 SHALL produce lo=a, hi=0.
REQ-021 start while busy=1 SHALL be ignored; the in-flight operation is not disturbed.
REQ-022 hilo_we while busy=0 SHALL write wdata to the selected register at the clock edge.
REQ-023 hilo_we while busy=1 SHALL be ignored.
REQ-024 hilo_we and start in the same idle cycle: start SHALL win and the write is dropped.
REQ-025 hi and lo SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-026 reset SHALL force state=IDLE and busy=0, done=0, hi=0, lo=0, counters=0, asynchronously.
REQ-027 Reset mid-operation SHALL discard the partial result; no done pulse follows.

Configuration
REQ-028 Macro MULDIV_MADD_EN defined: ops 4..7 SHALL behave per REQ-017.
REQ-029 MULDIV_MADD_EN undefined: ops 4..7 SHALL be ignored (no state change, busy stays 0) and the accumulate datapath SHALL be absent.

Structure
REQ-030 Shared package muldiv_pkg SHALL hold the op encodings, the state enum and the hilo_sel constants.
REQ-031 The iterative divider SHALL be the sub-module muldiv_div_seq (start, operands, signed flag, busy, quotient, remainder).
REQ-032 Multiply, accumulate, FSM and HI/LO SHALL remain in muldiv_unit.

Verification
REQ-033 MULT a=-3, b=7 (WIDTH=32): busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, single done pulse.
REQ-034 DIV a=-7, b=2: busy 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0: lo=0xFFFFFFFF, hi=7.
REQ-035 Busy-window rejection:
  - start with MULTU 2*3 while a DIV is running: ignored.
  - hilo_we while busy: ignored.
  - Final hi/lo equal the DIV result only.
REQ-036 Preload hi=0, lo=10 via hilo_we, then MADDU 4*5: lo=30; then MSUB 1*31: {hi,lo}=-1 (with MULDIV_MADD_EN).
REQ-037 Same sequence without MULDIV_MADD_EN: busy never rises; lo stays 10.
REQ-038 Reset asserted 10 cycles into a DIV: busy=0, hi=lo=0 immediately; no done; a new MULTU 2*3 then yields lo=6.
